// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHK, DONE} state_t;

    localparam int DWIDTH_DFLT    = 32;
    localparam int BYTES_PER_WORD = DWIDTH_DFLT / 8;

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

    // Byte-index register width; at least one bit even for 8-bit words.
    function automatic int idx_width(input int dw);
        return (dw > 8) ? $clog2(dw / 8) : 1;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer; 'word' already includes the byte being shifted in.
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              shift,
    input  logic              clear,
    output logic [DWIDTH-1:0] word,
    output logic              last
);

    localparam int BPW = bytes_per_word(DWIDTH);
    localparam int KW  = idx_width(DWIDTH);

    logic [KW-1:0]     k;
    logic [DWIDTH-1:0] acc;

    // Merging the incoming byte here lets the top capture a full word on the last accept.
    always_comb begin
        word = acc;
        for (int i = 0; i < BPW; i++)
            if (k == KW'(i)) word[8*i +: 8] = byte_in;
    end

    assign last = (k == KW'(BPW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k   <= '0;
            acc <= '0;
        end else if (clear) begin
            k <= '0;
        end else if (shift) begin
            acc <= word;
            k   <= last ? '0 : k + KW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction store; holds the CPU while loading.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH:0]   len,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [AWIDTH-1:0] waddr,
    output logic [DWIDTH-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              chk_err
);

    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH:0]   len_q, cnt, cnt_inc;
    logic [DWIDTH-1:0] word;
    logic              last, xfer;

    assign xfer    = byte_valid & byte_ready;
    assign cnt_inc = cnt + (AWIDTH+1)'(1);

    // Idle clears the byte index, so an aborted partial word is dropped.
    imem_byte_packer #(.DWIDTH(DWIDTH)) u_packer (
        .clk     (clk),
        .reset   (reset),
        .byte_in (byte_in),
        .shift   (xfer && state == LOAD),
        .clear   (state == IDLE),
        .word    (word),
        .last    (last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? DONE : LOAD;
            LOAD:  if (xfer && last) state_nxt = WRITE;
            WRITE: begin
                if (cnt_inc == len_q)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                else
                    state_nxt = LOAD;
            end
            CHK:   if (xfer) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state == LOAD || state == WRITE || state == CHK))
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            len_q <= '0;
            cnt   <= '0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start && len != '0) begin
                    addr  <= '0;
                    cnt   <= '0;
                    len_q <= (len > DEPTH) ? DEPTH : len;
                end
                LOAD: if (xfer && last) begin
                    wdata <= word;
                    waddr <= addr;
                end
                WRITE: begin
                    addr <= addr + AWIDTH'(1);
                    cnt  <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum     <= '0;
            chk_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && len != '0) begin
                    sum     <= '0;
                    chk_err <= 1'b0;
                end
                LOAD: if (xfer) sum <= sum + byte_in;
                CHK:  if (xfer && !abort) chk_err <= ((sum + byte_in) != 8'h00);
                default: ;
            endcase
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    assign byte_ready = (state == LOAD) || (state == CHK);
    assign busy       = (state == LOAD) || (state == WRITE) || (state == CHK);
    assign cpu_hold   = busy;
    assign we         = (state == WRITE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected words computed by hand.
module tb_imem_loader;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset, start, abort, byte_valid;
    logic [AW:0]   len;
    logic [7:0]    byte_in;
    logic          byte_ready, we, busy, done, cpu_hold, chk_err;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    imem_loader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            done_cnt = 0;
    int            rdy_in_wr = 0;
    logic [7:0]    tb_sum;
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];

    always @(negedge clk) begin
        if (we) begin
            log_a.push_back(waddr);
            log_d.push_back(wdata);
            if (byte_ready) rdy_in_wr++;
        end
        if (done) done_cnt++;
    end

    task automatic do_start(input logic [AW:0] l);
        start = 1'b1;
        len = l;
        tb_sum = 8'h00;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        byte_in = b;
        byte_valid = 1'b1;
        g = 0;
        while (byte_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (g >= 50) begin
            n_err++;
            $display("FAIL send_timeout: byte %02h never accepted", b);
        end
        tb_sum = tb_sum + b;
        @(negedge clk);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00 - tb_sum;
        send(c);
`endif
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 30) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done_timeout: done=%b want 1", nm, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        len = '0; byte_in = 8'h00;
        #12;
        n_cmp++;
        if ({busy, cpu_hold, we, done, byte_ready, chk_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, cpu_hold, we, done, byte_ready, chk_err});
        end
        n_cmp++;
        if (waddr !== '0 || wdata !== '0) begin
            n_err++;
            $display("FAIL reset_bus: waddr=%0d wdata=%08h want 0/0", waddr, wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b ready=%b want 0/0", busy, byte_ready);
        end
    endtask

    task automatic test_two_words();
        logic [7:0] b[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        int base, d0;
        base = log_a.size();
        d0 = done_cnt;
        do_start(7'd2);
        n_cmp++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            n_err++;
            $display("FAIL two_busy: busy=%b hold=%b want 1/1", busy, cpu_hold);
        end
        for (int i = 0; i < 8; i++) begin
            send(b[i]);
            if (i % 4 == 3) begin
                n_cmp++;
                if (we !== 1'b1) begin
                    n_err++;
                    $display("FAIL two_latency: we=%b want 1 after byte %0d", we, i);
                end
            end
        end
        finish_load();
        wait_done("two");
        n_cmp++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
            n_err++;
            $display("FAIL two_busy_done: busy=%b hold=%b want 0/0", busy, cpu_hold);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (log_a.size() != base + 2) begin
            n_err++;
            $display("FAIL two_count: writes=%0d want 2", log_a.size() - base);
        end else begin
            n_cmp++;
            if (log_a[base] !== 6'd0 || log_d[base] !== 32'h0000_0013) begin
                n_err++;
                $display("FAIL two_w0: addr=%0d data=%08h want 0/00000013", log_a[base], log_d[base]);
            end
            n_cmp++;
            if (log_a[base+1] !== 6'd1 || log_d[base+1] !== 32'h0010_0093) begin
                n_err++;
                $display("FAIL two_w1: addr=%0d data=%08h want 1/00100093", log_a[base+1], log_d[base+1]);
            end
        end
        n_cmp++;
        if (done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL two_done_cnt: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_throttled();
        logic [7:0] b[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int base;
        base = log_a.size();
        do_start(7'd1);
        for (int i = 0; i < 4; i++) begin
            send(b[i]);
            if (i < 3) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        n_cmp++;
        if (we !== 1'b1 || wdata !== 32'hDEAD_BEEF || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL thr_write: we=%b data=%08h ready=%b want 1/deadbeef/0", we, wdata, byte_ready);
        end
        finish_load();
        wait_done("thr");
        repeat (2) @(negedge clk);
        n_cmp++;
        if (log_a.size() != base + 1) begin
            n_err++;
            $display("FAIL thr_count: writes=%0d want 1", log_a.size() - base);
        end
        n_cmp++;
        if (wdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL thr_hold: wdata=%08h want deadbeef", wdata);
        end
    endtask

    task automatic test_clamp_zero();
        int base, d0, bad;
        logic [7:0] bi;
        base = log_a.size();
        d0 = done_cnt;
        do_start(7'd100);
        for (int i = 0; i < 64; i++) begin
            bi = 8'(i);
            send(bi);
            send(8'h11);
            send(8'h22);
            send(~bi);
        end
        finish_load();
        wait_done("clamp");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (log_a.size() != base + 64) begin
            n_err++;
            $display("FAIL clamp_count: writes=%0d want 64", log_a.size() - base);
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                bi = 8'(i);
                if (log_a[base+i] !== 6'(i) || log_d[base+i] !== {~bi, 8'h22, 8'h11, bi}) bad++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL clamp_data: %0d bad words want 0", bad);
            end
        end
        n_cmp++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clamp_done: dones=%0d busy=%b want 1/0", done_cnt - d0, busy);
        end
        base = log_a.size();
        start = 1'b1;
        len = '0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done: done=%b busy=%b want 1/0", done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || log_a.size() != base) begin
            n_err++;
            $display("FAIL zero_after: done=%b writes=%0d want 0/0", done, log_a.size() - base);
        end
    endtask

    task automatic test_abort();
        int base, d0;
        base = log_a.size();
        d0 = done_cnt;
        do_start(7'd3);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b ready=%b want 0/0", busy, byte_ready);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (log_a.size() != base + 1 || done_cnt != d0) begin
            n_err++;
            $display("FAIL abort_effects: writes=%0d dones=%0d want 1/0", log_a.size() - base, done_cnt - d0);
        end
        do_start(7'd1);
        send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
        finish_load();
        wait_done("abort_reload");
        @(negedge clk);
        n_cmp++;
        if (log_a.size() != base + 2) begin
            n_err++;
            $display("FAIL abort_reload_count: writes=%0d want 2", log_a.size() - base);
        end else if (log_a[base] !== 6'd0 || log_d[base] !== 32'h4433_2211 ||
                     log_a[base+1] !== 6'd0 || log_d[base+1] !== 32'hAABB_CCDD) begin
            n_err++;
            $display("FAIL abort_reload_data: %0d/%08h %0d/%08h want 0/44332211 0/aabbccdd",
                     log_a[base], log_d[base], log_a[base+1], log_d[base+1]);
        end
    endtask

    task automatic test_async_reset();
        do_start(7'd2);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        byte_valid = 1'b0;
        n_cmp++;
        if (we !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: we=%b busy=%b want 1/1", we, busy);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (we !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            n_err++;
            $display("FAIL areset_async: we=%b busy=%b hold=%b want 0/0/0", we, busy, cpu_hold);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        int d0;
        do_start(7'd1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hF6);
        byte_valid = 1'b0;
        wait_done("chk_ok");
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_err++;
            $display("FAIL chk_ok: chk_err=%b want 0", chk_err);
        end
        @(negedge clk);
        d0 = done_cnt;
        do_start(7'd1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hF7);
        byte_valid = 1'b0;
        wait_done("chk_bad");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (chk_err !== 1'b1 || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL chk_bad: chk_err=%b dones=%0d want 1/1", chk_err, done_cnt - d0);
        end
        do_start(7'd1);
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_err++;
            $display("FAIL chk_clear: chk_err=%b want 0", chk_err);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`else
        do_start(7'd1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        finish_load();
        wait_done("nochk");
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_err++;
            $display("FAIL nochk_err: chk_err=%b want 0", chk_err);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (rdy_in_wr != 0) begin
            n_err++;
            $display("FAIL ready_in_write: %0d cycles want 0", rdy_in_wr);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_throttled();
        test_clamp_zero();
        test_abort();
        test_async_reset();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the read-only instruction memory.
- Accepts a byte stream from a host link (for example a UART RX front end) and packs it little-endian into DWIDTH-bit words.
- Issues single-cycle write strobes into the instruction store's write port.
- Holds the CPU in reset while a program load is in progress.

Parameters:
- DWIDTH, 32, instruction word width; must be a multiple of 8.
- AWIDTH, 6, word-address width; store depth = 1<<AWIDTH = 64 words.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- len  in  AWIDTH+1  number of words to load; sampled with start.
- abort  in  1  cancels the load in progress.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction store write enable.
- waddr  out  AWIDTH  word write address.
- wdata  out  DWIDTH  word write data.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- cpu_hold  out  1  holds the CPU in reset; equal to busy.
- chk_err  out  1  checksum mismatch flag; sticky until the next start.

Behaviour:
- Reset: state IDLE; all outputs 0; internal address, byte index, word count and checksum cleared.
- A byte transfer occurs only when byte_valid and byte_ready are both 1 in the same cycle. byte_ready is a registered function of state only; it never depends on byte_valid.
- IDLE:
  - byte_ready=0, busy=0.
  - start with len==0: go to DONE.
  - start with len!=0: go to LOAD. Load len clamped to 1<<AWIDTH. Clear addr, byte index, checksum; clear chk_err.
- LOAD:
  - byte_ready=1, busy=1.
  - Each transfer writes byte_in into wdata[8*k +: 8], where k is the byte index 0..DWIDTH/8-1, then increments k.
  - The transfer with k = DWIDTH/8-1 goes to WRITE, with k wrapping to 0.
- WRITE (exactly 1 cycle):
  - we=1, waddr=addr, wdata=assembled word; byte_ready=0.
  - Next cycle: addr incremented. addr wraps modulo depth, which is unreachable after clamping.
  - If words written == clamped len: go to CHK when the feature is enabled, otherwise DONE. Else return to LOAD.
- DONE (1 cycle): done=1, busy=0; then IDLE.
- Latency: we asserts on the cycle after the last byte of each word is accepted.
- abort:
  - In LOAD, WRITE or CHK: go to IDLE next cycle, with no done and no further we.
  - A WRITE cycle with abort still performs its write.
  - A partial word is discarded.
  - abort has priority over every other transition.
- start outside IDLE is ignored. abort in IDLE is ignored.
- wdata and waddr hold their last values when we=0.
- Reset asserted mid-load returns to IDLE immediately. The CPU is released, since cpu_hold=0 during reset.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum of all payload bytes, modulo 256.
  - After the last WRITE, enter CHK with byte_ready=1 and accept exactly one checksum byte.
  - If (sum + byte) mod 256 != 0, set chk_err=1.
  - Then go to DONE; done still pulses.
  - len==0 skips CHK.
- Undefined: no CHK state and no sum register; chk_err is tied to 0.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE, LOAD, WRITE, CHK, DONE;
  - localparam helper BYTES_PER_WORD = DWIDTH/8;
  - byte-index width function.
- One sub-module, imem_byte_packer:
  - inputs: byte, shift strobe, clear;
  - outputs: packed word, last-byte flag;
  - parameterised by DWIDTH.

Test Plan:
1. Load two words: start, len=2; send bytes 13 00 00 00 93 00 10 00 with byte_valid held high.
   - Required: we at addr 0 with 0x00000013, then at addr 1 with 0x00100093.
   - done pulses once; busy/cpu_hold high from the cycle after start until DONE.
2. Throttled stream: byte_valid toggled 1,0,1,0 during a 1-word load of EF BE AD DE.
   - Required: wdata=0xDEADBEEF, one we only; byte_ready low during WRITE.
3. Clamp and zero length:
   - len=100 writes exactly 64 words (addr 0..63), then done.
   - len=0 gives done on the cycle after start, with no we.
4. Abort after 2 bytes of word 1 in a len=3 load.
   - Required: no we for word 1, no done; IDLE next cycle; a new start with len=1 loads 0xAABBCCDD at addr 0.
5. Asynchronous reset mid-word: assert reset between clock edges.
   - Required: busy, cpu_hold and we go to 0 immediately, without waiting for a clock edge.
6. With IMEM_LOADER_CHECKSUM_EN:
   - bytes 01 02 03 04 with checksum F6 gives chk_err=0;
   - checksum F7 gives chk_err=1 and done still pulses.
